// File: rtl/control_pkg.sv
// Shared encodings for the control pipeline: opcodes, ALU ops, result/immediate selects, forward selects.
// The control word is one packed struct, so a pipeline bubble is simply all zeros.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'b00000,
        ALU_SUB   = 5'b00001,
        ALU_AND   = 5'b00010,
        ALU_OR    = 5'b00011,
        ALU_XOR   = 5'b00100,
        ALU_SLT   = 5'b00101,
        ALU_SLTU  = 5'b00110,
        ALU_SLL   = 5'b00111,
        ALU_SRL   = 5'b01000,
        ALU_SRA   = 5'b01001,
        ALU_PASSB = 5'b01010,
        ALU_MUL   = 5'b10000,
        ALU_MULH  = 5'b10001,
        ALU_MULHSU= 5'b10010,
        ALU_MULHU = 5'b10011,
        ALU_DIV   = 5'b10100,
        ALU_DIVU  = 5'b10101,
        ALU_REM   = 5'b10110,
        ALU_REMU  = 5'b10111
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic     regwrite;
        res_src_t resultsrc;
        logic     memwrite;
        logic     jump;
        logic     branch;
        logic     alusrc;
        logic     alusrca;
        alu_op_t  alucontrol;
        logic     illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // sub only exists for register-register add; sra is selected by bit 30 for both shift forms
    function automatic alu_op_t alu_base_op(input logic [2:0] funct3, input logic bit30,
                                            input logic op5);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (op5 && bit30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational instruction decode into a control word; zero latency, no flow control.
// RV32M decode is enabled by CONTROL_PIPE_MEXT_EN; otherwise funct7=0000001 R-type is illegal.
module ctrl_decoder
    import control_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output imm_src_t    immsrc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];
    assign rd_o   = instr_i[11:7];

    always_comb begin
        ctrl_o   = CTRL_BUBBLE;
        immsrc_o = IMM_I;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_MEXT) begin
`ifdef CONTROL_PIPE_MEXT_EN
                    ctrl_o.regwrite   = 1'b1;
                    ctrl_o.alucontrol = alu_op_t'({2'b10, funct3});
`else
                    ctrl_o.illegal    = 1'b1;
`endif
                end else begin
                    ctrl_o.regwrite   = 1'b1;
                    ctrl_o.alucontrol = alu_base_op(funct3, funct7[5], 1'b1);
                end
            end
            OP_I: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.alucontrol = alu_base_op(funct3, funct7[5], 1'b0);
            end
            OP_LOAD: begin
                ctrl_o.regwrite  = 1'b1;
                ctrl_o.resultsrc = RES_MEM;
                ctrl_o.alusrc    = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                immsrc_o        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.alucontrol = ALU_SUB;
                immsrc_o          = IMM_B;
            end
            OP_JAL: begin
                ctrl_o.regwrite  = 1'b1;
                ctrl_o.resultsrc = RES_PC4;
                ctrl_o.jump      = 1'b1;
                immsrc_o         = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.regwrite  = 1'b1;
                ctrl_o.resultsrc = RES_PC4;
                ctrl_o.jump      = 1'b1;
                ctrl_o.alusrc    = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.alusrc     = 1'b1;
                ctrl_o.alucontrol = ALU_PASSB;
                immsrc_o          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.alusrca  = 1'b1;
                immsrc_o        = IMM_U;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB control staging with load-use stall, flush and forward selection; one stage per cycle.
// Load-use hazards stall F/D and inject an EX bubble; CONTROL_PIPE_MEXT_EN selects RV32M decode.
module control_pipe
    import control_pkg::*;
#(
    parameter int ALUCTRL_W = 5,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr_d,
    input  logic                 pcsrc_e,
    output logic [2:0]           immsrc_d,
    output logic                 regwrite_e,
    output logic                 regwrite_m,
    output logic                 regwrite_w,
    output logic [1:0]           resultsrc_e,
    output logic [1:0]           resultsrc_m,
    output logic [1:0]           resultsrc_w,
    output logic                 memwrite_e,
    output logic                 memwrite_m,
    output logic                 jump_e,
    output logic                 branch_e,
    output logic                 alusrc_e,
    output logic                 alusrca_e,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic                 illegal_e,
    output logic [REGADDR_W-1:0] rs1_e,
    output logic [REGADDR_W-1:0] rs2_e,
    output logic [REGADDR_W-1:0] rd_e,
    output logic [REGADDR_W-1:0] rd_m,
    output logic [REGADDR_W-1:0] rd_w,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [1:0]           forwarda_e,
    output logic [1:0]           forwardb_e
);

    ctrl_t          dec_ctrl;
    imm_src_t       dec_imm;
    logic [4:0]     dec_rs1, dec_rs2, dec_rd;

    ctrl_t          idex_ctrl_q, idex_ctrl_d;
    logic [REGADDR_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
    logic           regwrite_m_q, regwrite_m_d, memwrite_m_q, memwrite_m_d;
    res_src_t       resultsrc_m_q, resultsrc_m_d;
    logic [REGADDR_W-1:0] rd_m_q, rd_m_d;
    logic           regwrite_w_q, regwrite_w_d;
    res_src_t       resultsrc_w_q, resultsrc_w_d;
    logic [REGADDR_W-1:0] rd_w_q, rd_w_d;

    logic           lwstall, flush_ex;
    fwd_sel_t       fwd_a, fwd_b;

    ctrl_decoder u_dec (
        .instr_i  (instr_d),
        .ctrl_o   (dec_ctrl),
        .immsrc_o (dec_imm),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2),
        .rd_o     (dec_rd)
    );

    // x0 never creates a hazard, so a load to x0 does not stall
    assign lwstall  = (idex_ctrl_q.resultsrc == RES_MEM) && (rd_e_q != '0) &&
                      ((rd_e_q == REGADDR_W'(dec_rs1)) || (rd_e_q == REGADDR_W'(dec_rs2)));
    assign flush_ex = lwstall | pcsrc_e;

    always_comb begin
        idex_ctrl_d   = dec_ctrl;
        rs1_e_d       = REGADDR_W'(dec_rs1);
        rs2_e_d       = REGADDR_W'(dec_rs2);
        rd_e_d        = REGADDR_W'(dec_rd);
        if (flush_ex) begin
            idex_ctrl_d = CTRL_BUBBLE;
            rs1_e_d     = '0;
            rs2_e_d     = '0;
            rd_e_d      = '0;
        end
        regwrite_m_d  = idex_ctrl_q.regwrite;
        resultsrc_m_d = idex_ctrl_q.resultsrc;
        memwrite_m_d  = idex_ctrl_q.memwrite;
        rd_m_d        = rd_e_q;
        regwrite_w_d  = regwrite_m_q;
        resultsrc_w_d = resultsrc_m_q;
        rd_w_d        = rd_m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ctrl_q   <= CTRL_BUBBLE;
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            rd_e_q        <= '0;
            regwrite_m_q  <= 1'b0;
            resultsrc_m_q <= RES_ALU;
            memwrite_m_q  <= 1'b0;
            rd_m_q        <= '0;
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= RES_ALU;
            rd_w_q        <= '0;
        end else begin
            idex_ctrl_q   <= idex_ctrl_d;
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            regwrite_m_q  <= regwrite_m_d;
            resultsrc_m_q <= resultsrc_m_d;
            memwrite_m_q  <= memwrite_m_d;
            rd_m_q        <= rd_m_d;
            regwrite_w_q  <= regwrite_w_d;
            resultsrc_w_q <= resultsrc_w_d;
            rd_w_q        <= rd_w_d;
        end
    end

    // the younger producer in MEM takes precedence over WB
    always_comb begin
        fwd_a = FWD_RF;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs1_e_q))
            fwd_a = FWD_M;
        else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs1_e_q))
            fwd_a = FWD_W;
        fwd_b = FWD_RF;
        if (regwrite_m_q && (rd_m_q != '0) && (rd_m_q == rs2_e_q))
            fwd_b = FWD_M;
        else if (regwrite_w_q && (rd_w_q != '0) && (rd_w_q == rs2_e_q))
            fwd_b = FWD_W;
    end

    assign immsrc_d     = dec_imm;
    assign regwrite_e   = idex_ctrl_q.regwrite;
    assign resultsrc_e  = idex_ctrl_q.resultsrc;
    assign memwrite_e   = idex_ctrl_q.memwrite;
    assign jump_e       = idex_ctrl_q.jump;
    assign branch_e     = idex_ctrl_q.branch;
    assign alusrc_e     = idex_ctrl_q.alusrc;
    assign alusrca_e    = idex_ctrl_q.alusrca;
    assign alucontrol_e = ALUCTRL_W'(idex_ctrl_q.alucontrol);
    assign illegal_e    = idex_ctrl_q.illegal;
    assign rs1_e        = rs1_e_q;
    assign rs2_e        = rs2_e_q;
    assign rd_e         = rd_e_q;
    assign regwrite_m   = regwrite_m_q;
    assign resultsrc_m  = resultsrc_m_q;
    assign memwrite_m   = memwrite_m_q;
    assign rd_m         = rd_m_q;
    assign regwrite_w   = regwrite_w_q;
    assign resultsrc_w  = resultsrc_w_q;
    assign rd_w         = rd_w_q;
    assign stall_f      = lwstall;
    assign stall_d      = lwstall;
    assign flush_d      = pcsrc_e;
    assign flush_e      = flush_ex;
    assign forwarda_e   = fwd_a;
    assign forwardb_e   = fwd_b;

endmodule
